// File: rtl/button_bounce_gen_if.sv
// Request/status bundle between a press requester and the button emulator.
interface button_bounce_gen_if;
  logic press_req;
  logic pb_emul;
  logic busy;
  logic done;

  // Requester side: issues press requests and watches the emulated button.
  modport master (output press_req, input pb_emul, busy, done);
  // Emulator side.
  modport slave  (input press_req, output pb_emul, busy, done);
endinterface

// File: rtl/button_bounce_gen.sv
// Push-button emulator: a one-cycle press request becomes a bouncing press,
// a stable high hold, and a bouncing release. Bounce gaps are drawn from an
// 8-bit Galois LFSR reloaded on reset, so every waveform after reset repeats.
module button_bounce_gen #(
  parameter int         BOUNCE_EDGES = 4,
  parameter int         GAP_W        = 2,
  parameter int         HOLD_CYCLES  = 8,
  parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
  input logic               clk,
  input logic               rst_n,
  button_bounce_gen_if.slave bus
);

  typedef enum logic [1:0] {IDLE, PRESS, HOLD, RELEASE} state_t;

  localparam logic [15:0]    HOLD_INIT = 16'(HOLD_CYCLES);
  localparam logic [7:0]     LAST_EDGE = 8'(BOUNCE_EDGES);
  localparam logic [GAP_W:0] GAP_ONE   = (GAP_W+1)'(1);

  state_t         state_q, state_d;
  logic           pb_q, pb_d;
  logic           done_q, done_d;
  logic [7:0]     lfsr_q, lfsr_d;
  logic [GAP_W:0] gap_q, gap_d;
  logic [15:0]    hold_q, hold_d;
  logic [7:0]     edge_q, edge_d;

  logic [7:0]     lfsr_next;
  logic [GAP_W:0] gap_load;
  logic           last_toggle;

  // x^8+x^6+x^5+x^4+1 in right-shift Galois form (tap mask 0xB8).
  assign lfsr_next   = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);
  assign gap_load    = {1'b0, lfsr_q[GAP_W-1:0]} + GAP_ONE;
  // edge_q counts toggles already made in this phase; the pending one is final
  // when it would be toggle number BOUNCE_EDGES+1.
  assign last_toggle = (edge_q == LAST_EDGE);

  assign bus.pb_emul = pb_q;
  assign bus.done    = done_q;
  assign bus.busy    = (state_q != IDLE);

  // State and output registers; reset aborts any emulation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pb_q    <= 1'b0;
      done_q  <= 1'b0;
      lfsr_q  <= LFSR_SEED;
      gap_q   <= '0;
      hold_q  <= '0;
      edge_q  <= '0;
    end else begin
      state_q <= state_d;
      pb_q    <= pb_d;
      done_q  <= done_d;
      lfsr_q  <= lfsr_d;
      gap_q   <= gap_d;
      hold_q  <= hold_d;
      edge_q  <= edge_d;
    end
  end

  // Next-state and next-output decode; the LFSR only advances on a gap load.
  always_comb begin
    state_d = state_q;
    pb_d    = pb_q;
    done_d  = 1'b0;
    lfsr_d  = lfsr_q;
    gap_d   = gap_q;
    hold_d  = hold_q;
    edge_d  = edge_q;
    unique case (state_q)
      IDLE: begin
        if (bus.press_req) begin
          pb_d = 1'b1;
          if (BOUNCE_EDGES == 0) begin
            hold_d  = HOLD_INIT;
            state_d = HOLD;
          end else begin
            edge_d  = 8'd1;
            gap_d   = gap_load;
            lfsr_d  = lfsr_next;
            state_d = PRESS;
          end
        end
      end
      PRESS: begin
        if (gap_q == GAP_ONE) begin
          if (last_toggle) begin
            pb_d    = 1'b1;
            hold_d  = HOLD_INIT;
            state_d = HOLD;
          end else begin
            pb_d   = ~pb_q;
            edge_d = edge_q + 8'd1;
            gap_d  = gap_load;
            lfsr_d = lfsr_next;
          end
        end else begin
          gap_d = gap_q - GAP_ONE;
        end
      end
      HOLD: begin
        if (hold_q == 16'd1) begin
          pb_d = 1'b0;
          if (BOUNCE_EDGES == 0) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            edge_d  = 8'd1;
            gap_d   = gap_load;
            lfsr_d  = lfsr_next;
            state_d = RELEASE;
          end
        end else begin
          hold_d = hold_q - 16'd1;
        end
      end
      RELEASE: begin
        if (gap_q == GAP_ONE) begin
          if (last_toggle) begin
            pb_d    = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            pb_d   = ~pb_q;
            edge_d = edge_q + 8'd1;
            gap_d  = gap_load;
            lfsr_d = lfsr_next;
          end
        end else begin
          gap_d = gap_q - GAP_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_button_bounce_gen.sv
// Bench for button_bounce_gen: a cycle model predicts {pb_emul,busy,done} for
// every cycle of an accepted press; samples are queued at acceptance and
// compared each cycle. A second instance covers the no-bounce configuration.
module tb_button_bounce_gen;
  localparam int         BE   = 4;
  localparam int         GW   = 2;
  localparam int         HC   = 8;
  localparam logic [7:0] SEED = 8'hA5;

  logic clk;
  logic rst_n;

  button_bounce_gen_if ifa();
  button_bounce_gen_if ifb();

  button_bounce_gen #(.BOUNCE_EDGES(BE), .GAP_W(GW), .HOLD_CYCLES(HC), .LFSR_SEED(SEED))
    u_dut (.clk(clk), .rst_n(rst_n), .bus(ifa));

  button_bounce_gen #(.BOUNCE_EDGES(0), .GAP_W(1), .HOLD_CYCLES(8), .LFSR_SEED(SEED))
    u_dut0 (.clk(clk), .rst_n(rst_n), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [2:0] exp_q[$];
  logic [7:0] mlfsr;
  logic       mbusy;
  logic       prev_pb;
  int         rises, dones, accepts;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Galois LFSR step, polynomial x^8+x^6+x^5+x^4+1.
  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    logic       fb;
    logic [7:0] r;
    fb = s[0];
    r  = s >> 1;
    if (fb) r = r ^ 8'hB8;
    return r;
  endfunction

  task automatic push_gap(input logic lvl);
    int g;
    g     = 1 + int'(mlfsr & 8'((1 << GW) - 1));
    mlfsr = lfsr_step(mlfsr);
    repeat (g) exp_q.push_back({lvl, 2'b10});
  endtask

  // Expected samples for every cycle after the accepting edge.
  task automatic push_seq();
    logic lvl;
    accepts++;
    lvl = 1'b1;
    for (int k = 1; k <= BE + 1; k++) begin
      if (k > 1) lvl = ~lvl;
      if (k == BE + 1) repeat (HC) exp_q.push_back(3'b110);
      else push_gap(lvl);
    end
    lvl = 1'b0;
    for (int k = 1; k <= BE + 1; k++) begin
      if (k > 1) lvl = ~lvl;
      if (k == BE + 1) exp_q.push_back(3'b001);
      else push_gap(lvl);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    mlfsr   = SEED;
    mbusy   = 1'b0;
    prev_pb = 1'b0;
  endtask

  // One cycle: compare this cycle's sample, then drive press_req for the next edge.
  task automatic cyc(input logic req);
    logic [2:0] o, e;
    @(negedge clk);
    o = {ifa.pb_emul, ifa.busy, ifa.done};
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 3'b000;
    chk("sample", 32'(o), 32'(e));
    mbusy = e[1];
    if (o[2] && !prev_pb) rises++;
    if (o[0]) dones++;
    prev_pb = o[2];
    ifa.press_req = req;
    if (req && !mbusy) push_seq();
  endtask

  initial begin
    ifa.press_req = 1'b0;
    ifb.press_req = 1'b0;
    rst_n = 1'b0;
    model_reset();
    rises = 0; dones = 0; accepts = 0;
    repeat (3) @(negedge clk);
    chk("rst_pb",   32'(ifa.pb_emul), 0);
    chk("rst_busy", 32'(ifa.busy),    0);
    chk("rst_done", 32'(ifa.done),    0);
    rst_n = 1'b1;

    // Single press with default bouncing.
    cyc(1'b1);
    repeat (60) cyc(1'b0);
    chk("rises_1", 32'(rises), 32'(BE + 1));
    chk("dones_1", 32'(dones), 1);

    // Reset and replay: the seed sequence must repeat.
    @(negedge clk); rst_n = 1'b0; model_reset();
    @(negedge clk); rst_n = 1'b1;
    rises = 0; dones = 0;
    cyc(1'b1);
    repeat (60) cyc(1'b0);
    chk("rises_2", 32'(rises), 32'(BE + 1));
    chk("dones_2", 32'(dones), 1);

    // press_req held high: back-to-back emulations, busy-time requests dropped.
    rises = 0; dones = 0; accepts = 0;
    repeat (40) cyc(1'b1);
    repeat (60) cyc(1'b0);
    chk("b2b_dones", 32'(dones), 32'(accepts));
    chk("b2b_rises", 32'(rises), 32'(accepts * (BE + 1)));

    // Asynchronous reset mid-gap during PRESS.
    cyc(1'b1);
    cyc(1'b0);
    cyc(1'b0);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_pb",   32'(ifa.pb_emul), 0);
    chk("arst_busy", 32'(ifa.busy),    0);
    chk("arst_done", 32'(ifa.done),    0);
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    rises = 0; dones = 0;
    cyc(1'b1);
    repeat (60) cyc(1'b0);
    chk("replay_rises", 32'(rises), 32'(BE + 1));

    // Random request traffic.
    rises = 0; dones = 0; accepts = 0;
    repeat (400) cyc(logic'($urandom_range(0, 7) == 0));
    repeat (60) cyc(1'b0);
    chk("rnd_dones", 32'(dones),  32'(accepts));
    chk("rnd_rises", 32'(rises),  32'(accepts * (BE + 1)));

    // No-bounce instance: 8 cycles high, then one done pulse, then idle.
    @(negedge clk); ifb.press_req = 1'b1;
    @(negedge clk); ifb.press_req = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("nb_%0d", k), 32'({ifb.pb_emul, ifb.busy, ifb.done}),
          32'((k < 8) ? 3'b110 : (k == 8) ? 3'b001 : 3'b000));
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
